dma_io_endpoint: RTL and testbench
==================================

DMA_IO_ENDPOINT -- requirements
Module: dma_io_endpoint

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two).
REQ-002 SHALL have parameter THRESH, default 1, entries or free slots needed before DREQ asserts.
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port CLR  in  1  synchronous clear of FIFO, flags and DONE; latches MODE.
REQ-006 SHALL have port MODE  in  1  0 = source (device->memory, IOR), 1 = sink (memory->device, IOW).
REQ-007 SHALL have port WAITS  in  2  wait states inserted per DMA strobe.
REQ-008 SHALL have ports DACK, IOR, IOW, EOP  in  1 each  DMAC handshake and strobe inputs.
REQ-009 SHALL have port Data_in  in  8  DMAC write data (sink mode).
REQ-010 SHALL have ports DREQ, RDY  out  1 each  request to DMAC and ready/wait to DMAC.
REQ-011 SHALL have port Data_out  out  8  read data to DMAC (source mode).
REQ-012 SHALL have ports DEV_WR, DEV_RD  in  1 each  local device push/pop.
REQ-013 SHALL have ports DEV_WDATA  in  8 and DEV_RDATA  out  8  local device data.
REQ-014 SHALL have ports FULL, EMPTY, OVF, UNF, DONE  out  1 each  status flags.

Function
REQ-015 SHALL keep the FIFO as DEPTH x 8 with wrapping read/write pointers and a 0..DEPTH count; FULL = (count==DEPTH), EMPTY = (count==0).
REQ-016 Source mode: DEV_WR pushes DEV_WDATA; DMA side pops. Sink mode: DMA side pushes Data_in; DEV_RD pops to DEV_RDATA (registered, valid the cycle after DEV_RD).
REQ-017 DREQ SHALL be registered: 1 when !DONE && (source: count>=THRESH; sink: DEPTH-count>=THRESH), else 0.
REQ-018 DMA-side FSM states: IDLE, WAIT, XFER, HOLD.
REQ-019 IDLE -> WAIT when DACK && active strobe (IOR in source mode, IOW in sink mode) and WAITS>0; wait counter loads WAITS. IDLE -> XFER directly when WAITS==0.
REQ-020 WAIT: RDY=0, counter decrements each cycle; -> XFER when counter reaches 1.
REQ-021 XFER (exactly one cycle): RDY=1; source mode drives head entry on Data_out and pops; sink mode pushes Data_in; -> HOLD.
REQ-022 HOLD: RDY=1, no further transfer; -> IDLE when strobe or DACK deasserts. Exactly one transfer per strobe assertion.
REQ-023 RDY SHALL be 1 in IDLE, XFER and HOLD.
REQ-024 Data_out SHALL hold its last value outside XFER.
REQ-025 Simultaneous push and pop in one cycle: both performed, count unchanged, pointers both advance.
REQ-026 Push while FULL: ignored, OVF set sticky. DMA pop while EMPTY: Data_out=8'h00, UNF set sticky. DEV_RD while EMPTY: ignored, UNF set.
REQ-027 EOP sampled high: DONE set sticky, DREQ 0 next cycle; a transfer in progress still completes through XFER.
REQ-028 DACK dropping in WAIT: FSM -> IDLE, no transfer, no flag change.
REQ-029 MODE SHALL be sampled only on RST or CLR; changes at other times are ignored.

Reset
REQ-030 On RST (synchronous, active-high) or CLR: FSM=IDLE, count=0, pointers=0, DREQ=0, RDY=1, Data_out=8'h00, DEV_RDATA=8'h00, OVF=UNF=DONE=0, EMPTY=1, FULL=0.
REQ-031 RST or CLR mid-transfer SHALL abort it; no push or pop occurs in that cycle.
REQ-032 RST SHALL take priority over CLR, and CLR over all other inputs.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=0, WAIT=1, XFER=2, HOLD=3) and MODE_SRC=0/MODE_SNK=1 constants.
REQ-034 The FIFO SHALL be one sub-module, sync_fifo8 (push, pop, din, dout, count, full, empty); the handshake FSM stays in the top level.

Verification
REQ-035 Source, WAITS=0: push 05,0A,0F; three DACK+IOR strobes -> Data_out 05,0A,0F; RDY never low; EMPTY=1; DREQ=0 after the third pop.
REQ-036 Sink, WAITS=2: DACK+IOW with Data_in=3C -> RDY low for 2 cycles, push in XFER; DEV_RD -> DEV_RDATA=3C the next cycle.
REQ-037 Source: nine DEV_WR pushes with DEPTH=8 -> FULL after the 8th push, OVF=1 after the 9th, count stays 8.
REQ-038 EOP pulsed during a WAITS=3 strobe -> transfer completes, DONE=1, DREQ=0 next cycle and stays 0 until CLR.
REQ-039 Same-cycle DEV_WR and XFER pop at count=4 -> count stays 4, data order preserved.
REQ-040 RST asserted in WAIT -> all outputs at REQ-030 values next cycle, no pop occurred.

Source files
------------

// File: rtl/dma_io_endpoint_pkg.sv
// Shared definitions for the DMA I/O endpoint: handshake FSM encoding,
// transfer-direction constants and the DMA request rule.
package dma_io_endpoint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } dma_state_e;

  localparam logic MODE_SRC = 1'b0;
  localparam logic MODE_SNK = 1'b1;

  // Source mode wants enough queued bytes; sink mode wants enough free slots.
  function automatic logic dreq_calc(input logic done, input logic mode,
                                     input int count, input int depth,
                                     input int thresh);
    logic level_ok;
    if (mode == MODE_SRC) begin
      level_ok = (count >= thresh);
    end else begin
      level_ok = ((depth - count) >= thresh);
    end
    return (!done) && level_ok;
  endfunction

endpackage

// File: rtl/dma_io_endpoint_if.sv
// DMAC-facing bus of the endpoint: handshake, strobes, terminal count and
// the two data paths.
interface dma_io_endpoint_if;
  logic       DACK;
  logic       IOR;
  logic       IOW;
  logic       EOP;
  logic [7:0] Data_in;
  logic       DREQ;
  logic       RDY;
  logic [7:0] Data_out;

  modport master (
    output DACK, IOR, IOW, EOP, Data_in,
    input  DREQ, RDY, Data_out
  );

  modport slave (
    input  DACK, IOR, IOW, EOP, Data_in,
    output DREQ, RDY, Data_out
  );
endinterface

// File: rtl/dma_io_endpoint_sync_fifo8.sv
// Byte-wide synchronous FIFO with wrapping pointers and an occupancy count.
// Illegal pushes (full) and pops (empty) are dropped here as a second guard.
module sync_fifo8 #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign full   = (count_r == DEPTH_C);
  assign empty  = (count_r == {(AW + 1){1'b0}});
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    end
  end

endmodule

// File: rtl/dma_io_endpoint.sv
// DMA I/O endpoint: bridges a local byte device and an 8237-style DMAC
// through a FIFO, with programmable wait states and sticky status flags.
module dma_io_endpoint
  import dma_io_endpoint_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int THRESH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             MODE,
  input  logic [1:0]       WAITS,
  dma_io_endpoint_if.slave dma,
  input  logic             DEV_WR,
  input  logic             DEV_RD,
  input  logic [7:0]       DEV_WDATA,
  output logic [7:0]       DEV_RDATA,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVF,
  output logic             UNF,
  output logic             DONE
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  dma_state_e    state_r;
  dma_state_e    state_s;
  logic [1:0]    wcnt_r;
  logic [1:0]    wcnt_s;
  logic          rdy_r;
  logic          mode_r;
  logic          dreq_r;
  logic [7:0]    data_out_r;
  logic [7:0]    dev_rdata_r;
  logic          ovf_r;
  logic          unf_r;
  logic          done_r;
  logic          full_r;
  logic          empty_r;

  logic          clr_s;
  logic          strobe_s;
  logic          xfer_s;
  logic          dma_push_s;
  logic          dma_pop_s;
  logic          dev_push_s;
  logic          dev_pop_s;
  logic          push_req_s;
  logic          pop_req_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic [7:0]    push_data_s;
  logic          done_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [7:0]    fifo_dout_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  assign clr_s    = RST || CLR;
  assign strobe_s = dma.DACK && ((mode_r == MODE_SNK) ? dma.IOW : dma.IOR);
  assign xfer_s   = (state_r == ST_XFER);

  // Direction is fixed by the latched mode; the other side's requests are inert.
  assign dma_push_s  = xfer_s && (mode_r == MODE_SNK);
  assign dma_pop_s   = xfer_s && (mode_r == MODE_SRC);
  assign dev_push_s  = DEV_WR && (mode_r == MODE_SRC);
  assign dev_pop_s   = DEV_RD && (mode_r == MODE_SNK);
  assign push_req_s  = dma_push_s || dev_push_s;
  assign pop_req_s   = dma_pop_s || dev_pop_s;
  assign push_ok_s   = push_req_s && !fifo_full_s && !clr_s;
  assign pop_ok_s    = pop_req_s && !fifo_empty_s && !clr_s;
  assign push_data_s = (mode_r == MODE_SNK) ? dma.Data_in : DEV_WDATA;
  assign done_nxt_s  = !clr_s && (done_r || dma.EOP);
  assign count_nxt_s = clr_s ? {CW{1'b0}}
                             : (fifo_count_s + CW'(push_ok_s) - CW'(pop_ok_s));

  sync_fifo8 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (clr_s),
    .push  (push_ok_s),
    .pop   (pop_ok_s),
    .din   (push_data_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Handshake FSM next state: one transfer per strobe, after WAITS wait states.
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!strobe_s) begin
          state_s = ST_IDLE;
        end else if (WAITS == 2'd0) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_WAIT;
          wcnt_s  = WAITS;
        end
      end
      ST_WAIT: begin
        if (!dma.DACK) begin
          state_s = ST_IDLE;
        end else if (wcnt_r <= 2'd1) begin
          state_s = ST_XFER;
        end else begin
          wcnt_s = wcnt_r - 2'd1;
        end
      end
      ST_XFER: state_s = ST_HOLD;
      ST_HOLD: begin
        if (!strobe_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake FSM state, wait counter and registered RDY.
  always_ff @(posedge CLK) begin
    if (clr_s) begin
      state_r <= ST_IDLE;
      wcnt_r  <= 2'd0;
      rdy_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
      rdy_r   <= (state_s != ST_WAIT);
    end
  end

  // Data registers and status; DREQ and flags track the post-edge occupancy.
  always_ff @(posedge CLK) begin
    if (clr_s) begin
      mode_r      <= MODE;
      dreq_r      <= 1'b0;
      data_out_r  <= 8'h00;
      dev_rdata_r <= 8'h00;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      done_r      <= 1'b0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
    end else begin
      mode_r <= mode_r;
      dreq_r <= dreq_calc(done_nxt_s, mode_r, int'(count_nxt_s), DEPTH, THRESH);
      if (dma_pop_s) begin
        data_out_r <= fifo_empty_s ? 8'h00 : fifo_dout_s;
      end
      if (dev_pop_s && !fifo_empty_s) begin
        dev_rdata_r <= fifo_dout_s;
      end
      ovf_r   <= ovf_r || (push_req_s && fifo_full_s);
      unf_r   <= unf_r || (pop_req_s && fifo_empty_s);
      done_r  <= done_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  assign dma.DREQ     = dreq_r;
  assign dma.RDY      = rdy_r;
  assign dma.Data_out = data_out_r;
  assign DEV_RDATA    = dev_rdata_r;
  assign FULL         = full_r;
  assign EMPTY        = empty_r;
  assign OVF          = ovf_r;
  assign UNF          = unf_r;
  assign DONE         = done_r;

endmodule

// File: tb/tb_dma_io_endpoint.sv
// Self-checking bench for dma_io_endpoint: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_dma_io_endpoint;
  localparam int DEPTH  = 8;
  localparam int THRESH = 1;

  logic       CLK = 1'b0;
  logic       RST, CLR, MODE, DEV_WR, DEV_RD;
  logic [1:0] WAITS;
  logic [7:0] DEV_WDATA, DEV_RDATA;
  logic       FULL, EMPTY, OVF, UNF, DONE;

  always #5 CLK = ~CLK;

  dma_io_endpoint_if dif();

  dma_io_endpoint #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .MODE(MODE), .WAITS(WAITS), .dma(dif),
    .DEV_WR(DEV_WR), .DEV_RD(DEV_RD), .DEV_WDATA(DEV_WDATA), .DEV_RDATA(DEV_RDATA),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF), .DONE(DONE)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %02h required %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             cyc = 0;
  int             t0 = 0;
  int             wv = 0;
  bit             eng = 1'b0;
  bit             m_valid = 1'b0;
  byte unsigned   q[$];
  logic           m_mode = 1'b0;
  logic [7:0]     m_dout = 8'h00, m_drd = 8'h00, head_m;
  logic           m_ovf = 1'b0, m_unf = 1'b0, m_done = 1'b0, m_dreq = 1'b0, m_rdy = 1'b1;
  bit             strobe_m, xfer_m, full_m, empty_m;
  bit             dma_pop_m, dma_push_m, dev_push_m, dev_pop_m;

  // Transaction timeline: strobe seen at edge t0, transfer at edge t0+wv+1.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (RST || CLR) begin
      q.delete();
      m_mode = MODE; m_dout = 8'h00; m_drd = 8'h00;
      m_ovf = 1'b0; m_unf = 1'b0; m_done = 1'b0; m_dreq = 1'b0; m_rdy = 1'b1;
      eng = 1'b0; m_valid = 1'b1;
    end else begin
      strobe_m = dif.DACK && (m_mode ? dif.IOW : dif.IOR);
      xfer_m = 1'b0;
      if (eng) begin
        if ((cyc - t0) <= wv && !dif.DACK) eng = 1'b0;
        else if ((cyc - t0) == wv + 1) xfer_m = 1'b1;
        else if ((cyc - t0) > wv + 1 && !strobe_m) eng = 1'b0;
      end else if (strobe_m) begin
        eng = 1'b1; t0 = cyc; wv = int'(WAITS);
      end
      full_m = (q.size() == DEPTH);
      empty_m = (q.size() == 0);
      head_m = empty_m ? 8'h00 : q[0];
      dma_pop_m  = xfer_m && !m_mode;
      dma_push_m = xfer_m && m_mode;
      dev_push_m = DEV_WR && !m_mode;
      dev_pop_m  = DEV_RD && m_mode;
      if ((dma_pop_m || dev_pop_m) && empty_m) m_unf = 1'b1;
      if ((dma_push_m || dev_push_m) && full_m) m_ovf = 1'b1;
      if (dma_pop_m) m_dout = head_m;
      if (dev_pop_m && !empty_m) m_drd = head_m;
      if ((dma_pop_m || dev_pop_m) && !empty_m) void'(q.pop_front());
      if ((dma_push_m || dev_push_m) && !full_m) q.push_back(m_mode ? dif.Data_in : DEV_WDATA);
      if (dif.EOP) m_done = 1'b1;
      m_dreq = !m_done && (!m_mode ? (q.size() >= THRESH) : ((DEPTH - q.size()) >= THRESH));
      m_rdy = !(eng && (cyc - t0) < wv);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("m_dreq", {7'd0, dif.DREQ}, {7'd0, m_dreq});
      chk("m_rdy", {7'd0, dif.RDY}, {7'd0, m_rdy});
      chk("m_data_out", dif.Data_out, m_dout);
      chk("m_dev_rdata", DEV_RDATA, m_drd);
      chk("m_full", {7'd0, FULL}, {7'd0, (q.size() == DEPTH)});
      chk("m_empty", {7'd0, EMPTY}, {7'd0, (q.size() == 0)});
      chk("m_ovf", {7'd0, OVF}, {7'd0, m_ovf});
      chk("m_unf", {7'd0, UNF}, {7'd0, m_unf});
      chk("m_done", {7'd0, DONE}, {7'd0, m_done});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle();
    dif.DACK = 1'b0; dif.IOR = 1'b0; dif.IOW = 1'b0; dif.EOP = 1'b0;
    dif.Data_in = 8'h00; DEV_WR = 1'b0; DEV_RD = 1'b0; DEV_WDATA = 8'h00;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dreq"}, {7'd0, dif.DREQ}, 8'h00);
    chk({tag, "_rdy"}, {7'd0, dif.RDY}, 8'h01);
    chk({tag, "_data_out"}, dif.Data_out, 8'h00);
    chk({tag, "_dev_rdata"}, DEV_RDATA, 8'h00);
    chk({tag, "_empty"}, {7'd0, EMPTY}, 8'h01);
    chk({tag, "_full"}, {7'd0, FULL}, 8'h00);
    chk({tag, "_ovf"}, {7'd0, OVF}, 8'h00);
    chk({tag, "_unf"}, {7'd0, UNF}, 8'h00);
    chk({tag, "_done"}, {7'd0, DONE}, 8'h00);
  endtask

  task automatic clear_to(input logic mode, input logic [1:0] w);
    idle(); CLR = 1'b1; MODE = mode; WAITS = w; step(); CLR = 1'b0;
  endtask

  task automatic dev_push(input logic [7:0] d);
    DEV_WR = 1'b1; DEV_WDATA = d; step(); DEV_WR = 1'b0;
  endtask

  // One WAITS=0 source strobe: strobe edge, XFER edge, then release.
  task automatic src_read(input string nm, input logic [7:0] exp);
    dif.DACK = 1'b1; dif.IOR = 1'b1; step();
    chk({nm, "_rdy_a"}, {7'd0, dif.RDY}, 8'h01);
    step();
    chk({nm, "_rdy_b"}, {7'd0, dif.RDY}, 8'h01);
    chk({nm, "_data"}, dif.Data_out, exp);
    dif.DACK = 1'b0; dif.IOR = 1'b0; step();
  endtask

  logic [7:0] ev;

  initial begin
    idle(); CLR = 1'b0; MODE = 1'b0; WAITS = 2'd0; RST = 1'b1;
    step(); RST = 1'b0;
    reset_checks("reset");

    // Source, no wait states: three bytes out in order.
    dev_push(8'h05);
    chk("src_dreq_first", {7'd0, dif.DREQ}, 8'h01);
    dev_push(8'h0A); dev_push(8'h0F);
    src_read("src0", 8'h05);
    src_read("src1", 8'h0A);
    src_read("src2", 8'h0F);
    chk("src_empty", {7'd0, EMPTY}, 8'h01);
    chk("src_dreq_last", {7'd0, dif.DREQ}, 8'h00);

    // Sink with two wait states, then device read-back.
    clear_to(1'b1, 2'd2);
    dif.DACK = 1'b1; dif.IOW = 1'b1; dif.Data_in = 8'h3C; step();
    chk("snk_rdy_w1", {7'd0, dif.RDY}, 8'h00);
    step();
    chk("snk_rdy_w2", {7'd0, dif.RDY}, 8'h00);
    step();
    chk("snk_rdy_xfer", {7'd0, dif.RDY}, 8'h01);
    chk("snk_empty_pre", {7'd0, EMPTY}, 8'h01);
    step();
    chk("snk_empty_post", {7'd0, EMPTY}, 8'h00);
    idle(); step();
    DEV_RD = 1'b1; step(); DEV_RD = 1'b0;
    chk("snk_dev_rdata", DEV_RDATA, 8'h3C);
    chk("snk_empty_end", {7'd0, EMPTY}, 8'h01);

    // Overflow on the ninth push.
    clear_to(1'b0, 2'd0);
    for (int i = 0; i < 8; i++) dev_push(8'(i + 16));
    chk("ovf_full8", {7'd0, FULL}, 8'h01);
    chk("ovf_flag8", {7'd0, OVF}, 8'h00);
    dev_push(8'hEE);
    chk("ovf_full9", {7'd0, FULL}, 8'h01);
    chk("ovf_flag9", {7'd0, OVF}, 8'h01);

    // EOP during a three-wait-state strobe.
    clear_to(1'b0, 2'd3);
    dev_push(8'h11); dev_push(8'h22);
    dif.DACK = 1'b1; dif.IOR = 1'b1; step();
    chk("eop_rdy_w1", {7'd0, dif.RDY}, 8'h00);
    dif.EOP = 1'b1; step(); dif.EOP = 1'b0;
    chk("eop_done", {7'd0, DONE}, 8'h01);
    chk("eop_dreq", {7'd0, dif.DREQ}, 8'h00);
    step(); step(); step();
    chk("eop_data", dif.Data_out, 8'h11);
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("eop_dreq_stays", {7'd0, dif.DREQ}, 8'h00);
    chk("eop_done_stays", {7'd0, DONE}, 8'h01);
    clear_to(1'b0, 2'd0);
    chk("eop_done_clr", {7'd0, DONE}, 8'h00);
    dev_push(8'h33);
    chk("eop_dreq_after_clr", {7'd0, dif.DREQ}, 8'h01);

    // Simultaneous device push and DMA pop at count 4.
    clear_to(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) dev_push(8'(8'hA0 + i));
    dif.DACK = 1'b1; dif.IOR = 1'b1; step();
    DEV_WR = 1'b1; DEV_WDATA = 8'hA4; step(); DEV_WR = 1'b0;
    chk("same_data", dif.Data_out, 8'hA0);
    chk("same_full", {7'd0, FULL}, 8'h00);
    chk("same_empty", {7'd0, EMPTY}, 8'h00);
    dif.DACK = 1'b0; dif.IOR = 1'b0; step();
    for (int k = 1; k <= 4; k++) begin
      ev = 8'hA0 + 8'(k);
      src_read("same_drain", ev);
    end
    chk("same_empty_end", {7'd0, EMPTY}, 8'h01);

    // Reset asserted while waiting.
    clear_to(1'b0, 2'd3);
    dev_push(8'h55); dev_push(8'h66);
    dif.DACK = 1'b1; dif.IOR = 1'b1; step();
    chk("rstw_rdy", {7'd0, dif.RDY}, 8'h00);
    RST = 1'b1; step(); RST = 1'b0; idle();
    reset_checks("rst_in_wait");

    // Randomized traffic, checked every cycle by the model compare.
    for (int i = 0; i < 4000; i++) begin
      RST = ($urandom_range(0, 599) == 0);
      CLR = ($urandom_range(0, 149) == 0);
      MODE = 1'($urandom_range(0, 1));
      WAITS = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) dif.DACK = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) dif.IOR = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) dif.IOW = 1'($urandom_range(0, 1));
      dif.EOP = ($urandom_range(0, 99) == 0);
      dif.Data_in = 8'($urandom);
      DEV_WR = ($urandom_range(0, 2) == 0);
      DEV_RD = ($urandom_range(0, 2) == 0);
      DEV_WDATA = 8'($urandom);
      step();
    end
    RST = 1'b0; CLR = 1'b0; idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
